regfile_write_sched: RTL
========================

Name: regfile_write_sched

Overview:
- Single-write-port scheduler between the SEQ writeback stage and the 15-entry register file.
- Decodes each retiring instruction (icode, cnd, rA, rB) into its E-destination and M-destination writes.
- Serialises popq's dual write onto one port over two cycles.
- Arbitrates the port against a debug/initialisation write requester, with a bounded-starvation guarantee for that requester.

Parameters:
- STARVE_LIMIT, 4: max consecutive writeback acceptances while a debug request waits; range 1..15.
- REG_SP, 4: register index of %rsp.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback transaction offered.
- wb_ready  out  1  scheduler accepts writeback this cycle.
- wb_icode  in  4  instruction code.
- wb_cnd  in  1  condition flag (cmovXX).
- wb_ra  in  4  rA field.
- wb_rb  in  4  rB field.
- wb_vale  in  64  valE.
- wb_valm  in  64  valM.
- dbg_valid  in  1  debug write offered.
- dbg_ready  out  1  debug write accepted this cycle.
- dbg_addr  in  4  debug target register.
- dbg_data  in  64  debug write data.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  4  write address (registered).
- rf_wdata  out  64  write data (registered).
- wb_done  out  1  one-cycle pulse when a writeback transaction's final slot issues.

Behaviour:

Reset
- Asynchronous on reset_n low. Clears state to IDLE, starve_cnt to 0, and drives rf_wen=0, rf_waddr=0, rf_wdata=0, wb_done=0.
- A pending second write (state SECOND) is discarded.
- Combinational outputs during reset: wb_ready=0, dbg_ready=0.

Handshake
- A transfer occurs on a rising edge where valid && ready.
- Inputs are sampled only at that edge.
- At most one of wb/dbg is accepted per cycle.

Decode (at acceptance)
- icode 2: dstE = rB if cnd=1, else none.
- icode 3, 6: dstE = rB.
- icode 5: dstM = rA.
- icode 8, 9, A: dstE = REG_SP.
- icode B: dstE = REG_SP, dstM = rA.
- All other icodes: no writes.
- Any destination equal to 15 (RNONE) counts as no write.

FSM: IDLE, SECOND
- IDLE
  - wb_ready = !dbg_grant_now.
  - dbg_ready = dbg_valid && (!wb_valid || starve_cnt == STARVE_LIMIT).
- On wb acceptance at edge t, cycle t+1 (registered):
  - If dstE is valid: rf_wen=1, rf_waddr=dstE, rf_wdata=valE.
  - Else if dstM is valid: rf_wen=1, rf_waddr=dstM, rf_wdata=valM.
  - Else: rf_wen=0.
  - If both dstE and dstM are valid: go to SECOND, latch dstM/valM, wb_done=0.
  - Otherwise: wb_done=1.
- SECOND
  - wb_ready=0, dbg_ready=0.
  - Next cycle: rf_wen=1, rf_waddr=dstM, rf_wdata=valM, wb_done=1; return to IDLE.
  - M is always written after E, so popq with rA=%rsp leaves valM in %rsp.
- On dbg acceptance: next cycle rf_wen = (dbg_addr != 15), rf_waddr=dbg_addr, rf_wdata=dbg_data, wb_done=0.
- Cycles with no acceptance and not in SECOND: rf_wen=0, wb_done=0. rf_waddr/rf_wdata hold their previous values.

Starvation counter (4-bit)
- Increments on each wb acceptance while dbg_valid=1; saturates at STARVE_LIMIT.
- Clears on dbg acceptance or whenever dbg_valid=0 in IDLE.

Throughput and latency
- Single-write transaction: 1 per cycle.
- popq: 2 cycles, during which wb_ready is low for one cycle.
- Latency from acceptance to first write: exactly 1 cycle.

Test Plan:
1. Reset with reset_n low mid-popq (state SECOND) -> rf_wen=0 immediately (asynchronous); after release no M write ever appears; wb_ready=1 in IDLE.
2. irmovq back-to-back: icode 3, rB=2, valE=0x1234 then icode 6, rB=3, valE=0x55 -> rf writes (2,0x1234) then (3,0x55) on consecutive cycles, wb_done high both cycles.
3. popq: icode B, rA=1, valE=0x100, valM=0xBEEF -> (4,0x100) then (1,0xBEEF); wb_ready=0 on the cycle between; wb_done only on the second write. Repeat with rA=4 -> final %rsp write is valM.
4. cmov: icode 2, cnd=0, rB=5 -> no rf_wen, wb_done=1. Same with cnd=1, valE=7 -> write (5,7). Also icode 5 with rA=15 -> no write.
5. Starvation: wb_valid held high with icode 3 and dbg_valid high, STARVE_LIMIT=4 -> exactly 4 wb writes, then dbg write (dbg_addr=7, 0xAA) in the 5th slot with wb_ready=0 that cycle, then wb resumes.
6. Debug alone: dbg_addr=15 -> dbg_ready=1, no rf_wen. dbg_addr=0, data=0xFF -> write (0,0xFF) one cycle after acceptance.

Source files
------------

// File: rtl/regfile_write_sched.sv
// regfile_write_sched
// Single-write-port scheduler between the SEQ writeback stage and the
// 15-entry register file. Each accepted writeback is decoded into its
// E-destination and M-destination writes. popq (two writes) is serialised
// over two cycles, E first and then M, so popq %rsp leaves valM in %rsp.
// A debug/initialisation requester shares the port. It wins when the
// writeback side is idle, or once STARVE_LIMIT writebacks have been taken
// while it was waiting.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   wb_valid/wb_ready     writeback handshake
//   wb_icode, wb_cnd      instruction code and cmov condition
//   wb_ra, wb_rb          register fields
//   wb_vale, wb_valm      result values
//   dbg_valid/dbg_ready   debug write handshake
//   dbg_addr, dbg_data    debug write target and value
//   rf_wen/waddr/wdata    registered register-file write port
//   wb_done               pulse when a writeback's final slot issues
module regfile_write_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int REG_SP       = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_icode,
  input  logic        wb_cnd,
  input  logic [3:0]  wb_ra,
  input  logic [3:0]  wb_rb,
  input  logic [63:0] wb_vale,
  input  logic [63:0] wb_valm,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [3:0]  dbg_addr,
  input  logic [63:0] dbg_data,
  output logic        rf_wen,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        wb_done
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  localparam logic [3:0] RNONE   = 4'd15;
  localparam logic [3:0] SP_ADDR = 4'(REG_SP);
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  // Returns {dst_e, dst_m}; RNONE marks "no write".
  function automatic logic [7:0] decode_dst(
    input logic [3:0] icode,
    input logic       cnd,
    input logic [3:0] ra,
    input logic [3:0] rb
  );
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h2: begin
        if (cnd) begin
          dst_e = rb;
        end else begin
          dst_e = RNONE;
        end
      end
      4'h3, 4'h6:        dst_e = rb;
      4'h5:              dst_m = ra;
      4'h8, 4'h9, 4'hA:  dst_e = SP_ADDR;
      4'hB: begin
        dst_e = SP_ADDR;
        dst_m = ra;
      end
      default: begin
        dst_e = RNONE;
        dst_m = RNONE;
      end
    endcase
    return {dst_e, dst_m};
  endfunction

  state_t      state_r;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  pend_addr_r;
  logic [63:0] pend_data_r;

  logic [7:0]  dst_s;
  logic [3:0]  dst_e_s;
  logic [3:0]  dst_m_s;
  logic        e_ok_s;
  logic        m_ok_s;
  logic        in_idle_s;
  logic        dbg_grant_s;
  logic        wb_acc_s;
  logic        dbg_acc_s;
  logic [3:0]  starve_inc_s;

  // Decode, arbitration and handshake qualification.
  always_comb begin
    dst_s     = decode_dst(wb_icode, wb_cnd, wb_ra, wb_rb);
    dst_e_s   = dst_s[7:4];
    dst_m_s   = dst_s[3:0];
    e_ok_s    = (dst_e_s != RNONE);
    m_ok_s    = (dst_m_s != RNONE);
    in_idle_s = (state_r == ST_IDLE);
    // Debug wins when writeback is absent or has starved it long enough.
    // Both readies are forced low while reset is asserted.
    dbg_grant_s = reset_n && in_idle_s && dbg_valid &&
                  (!wb_valid || (starve_cnt_r == LIMIT));
    dbg_ready = dbg_grant_s;
    wb_ready  = reset_n && in_idle_s && !dbg_grant_s;
    wb_acc_s  = wb_valid && wb_ready;
    dbg_acc_s = dbg_valid && dbg_ready;
    if (starve_cnt_r < LIMIT) begin
      starve_inc_s = starve_cnt_r + 4'd1;
    end else begin
      starve_inc_s = starve_cnt_r;
    end
  end

  // Scheduler state, starvation counter and registered write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= 4'd0;
      pend_addr_r  <= 4'd0;
      pend_data_r  <= 64'd0;
      rf_wen       <= 1'b0;
      rf_waddr     <= 4'd0;
      rf_wdata     <= 64'd0;
      wb_done      <= 1'b0;
    end else begin
      case (state_r)
        ST_SECOND: begin
          // Deferred M write of a dual-destination instruction.
          rf_wen   <= 1'b1;
          rf_waddr <= pend_addr_r;
          rf_wdata <= pend_data_r;
          wb_done  <= 1'b1;
          state_r  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (dbg_acc_s) begin
            rf_wen       <= (dbg_addr != RNONE);
            rf_waddr     <= dbg_addr;
            rf_wdata     <= dbg_data;
            wb_done      <= 1'b0;
            starve_cnt_r <= 4'd0;
          end else if (wb_acc_s) begin
            if (e_ok_s) begin
              rf_wen   <= 1'b1;
              rf_waddr <= dst_e_s;
              rf_wdata <= wb_vale;
            end else if (m_ok_s) begin
              rf_wen   <= 1'b1;
              rf_waddr <= dst_m_s;
              rf_wdata <= wb_valm;
            end else begin
              rf_wen <= 1'b0;
            end
            if (e_ok_s && m_ok_s) begin
              state_r     <= ST_SECOND;
              pend_addr_r <= dst_m_s;
              pend_data_r <= wb_valm;
              wb_done     <= 1'b0;
            end else begin
              wb_done <= 1'b1;
            end
            if (dbg_valid) begin
              starve_cnt_r <= starve_inc_s;
            end else begin
              starve_cnt_r <= 4'd0;
            end
          end else begin
            // No transfer: address/data hold their previous values.
            rf_wen  <= 1'b0;
            wb_done <= 1'b0;
            if (!dbg_valid) begin
              starve_cnt_r <= 4'd0;
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rf_wen  <= 1'b0;
          wb_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
